// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared state encoding and AXI response codes for the read arbiter
package axi4_lite_pkg;

   // Arbiter transaction phases: wait for a request, drive AR, steer R
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_rd_arb_grant.sv
// rtl/axi4_lite_rd_arb_grant.sv - 2-way read grant pick; AXI_RD_ARB_ROUND_ROBIN_EN selects round-robin ties
module axi4_lite_rd_arb_grant
   import axi4_lite_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       winner,
   output logic       winner_valid
);

`ifndef AXI_RD_ARB_ROUND_ROBIN_EN
   // Fixed priority ignores history; keep the input connected for a uniform interface
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   // Pick a winner; with no request the winner defaults to requester 0
   always_comb begin
      winner_valid = |req;
      winner       = 1'b0;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
      if (req == 2'b11) begin
         winner = ~last_grant;
      end else begin
         winner = req[1];
      end
`else
      winner = req[1];
`endif
   end

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// rtl/axi4_lite_read_arbiter.sv - two-requester AXI4-Lite read arbiter, one outstanding read; AXI_RD_ARB_ROUND_ROBIN_EN enables round-robin ties
module axi4_lite_read_arbiter
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [ADDR_WIDTH-1:0] S0_AXI_ARADDR,
   input  logic                  S0_AXI_ARVALID,
   output logic                  S0_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0] S0_AXI_RDATA,
   output logic [1:0]            S0_AXI_RRESP,
   output logic                  S0_AXI_RVALID,
   input  logic                  S0_AXI_RREADY,

   input  logic [ADDR_WIDTH-1:0] S1_AXI_ARADDR,
   input  logic                  S1_AXI_ARVALID,
   output logic                  S1_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0] S1_AXI_RDATA,
   output logic [1:0]            S1_AXI_RRESP,
   output logic                  S1_AXI_RVALID,
   input  logic                  S1_AXI_RREADY,

   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY,

   output logic                  busy,
   output logic                  grant_id
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  grant_id_q, grant_id_d;
   logic                  last_grant_q, last_grant_d;

   logic                  winner;
   logic                  winner_valid;
   logic                  granted_rready;

   axi4_lite_rd_arb_grant u_grant (
      .req          ({S1_AXI_ARVALID, S0_AXI_ARVALID}),
      .last_grant   (last_grant_q),
      .winner       (winner),
      .winner_valid (winner_valid)
   );

   assign granted_rready = grant_id_q ? S1_AXI_RREADY : S0_AXI_RREADY;

   // State and grant registers; reset drops any in-flight transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         grant_id_q   <= 1'b0;
         last_grant_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next state: grant in IDLE, wait for AR handshake, then for R handshake
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (winner_valid) begin
               addr_d       = winner ? S1_AXI_ARADDR : S0_AXI_ARADDR;
               grant_id_d   = winner;
               last_grant_d = winner;
               state_d      = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (M_AXI_ARREADY) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (M_AXI_RVALID && granted_rready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs: AR acceptance in IDLE, AR drive in ADDR, R steering in DATA
   always_comb begin
      S0_AXI_ARREADY = 1'b0;
      S1_AXI_ARREADY = 1'b0;
      S0_AXI_RDATA   = '0;
      S0_AXI_RRESP   = 2'b00;
      S0_AXI_RVALID  = 1'b0;
      S1_AXI_RDATA   = '0;
      S1_AXI_RRESP   = 2'b00;
      S1_AXI_RVALID  = 1'b0;
      M_AXI_ARADDR   = '0;
      M_AXI_ARVALID  = 1'b0;
      M_AXI_RREADY   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            S0_AXI_ARREADY = ~winner;
            S1_AXI_ARREADY = winner;
         end
         ST_ADDR: begin
            M_AXI_ARVALID = 1'b1;
            M_AXI_ARADDR  = addr_q;
         end
         ST_DATA: begin
            M_AXI_RREADY = granted_rready;
            if (grant_id_q) begin
               S1_AXI_RVALID = M_AXI_RVALID;
               S1_AXI_RDATA  = M_AXI_RDATA;
               S1_AXI_RRESP  = M_AXI_RRESP;
            end else begin
               S0_AXI_RVALID = M_AXI_RVALID;
               S0_AXI_RDATA  = M_AXI_RDATA;
               S0_AXI_RRESP  = M_AXI_RRESP;
            end
         end
         default: begin
         end
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// tb/tb_axi4_lite_read_arbiter.sv - scoreboard bench for axi4_lite_read_arbiter; expectations follow AXI_RD_ARB_ROUND_ROBIN_EN
module tb_axi4_lite_read_arbiter;
   import axi4_lite_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] S0_AXI_ARADDR, S1_AXI_ARADDR, M_AXI_ARADDR;
   logic        S0_AXI_ARVALID, S1_AXI_ARVALID, M_AXI_ARVALID;
   logic        S0_AXI_ARREADY, S1_AXI_ARREADY, M_AXI_ARREADY;
   logic [31:0] S0_AXI_RDATA, S1_AXI_RDATA, M_AXI_RDATA;
   logic [1:0]  S0_AXI_RRESP, S1_AXI_RRESP, M_AXI_RRESP;
   logic        S0_AXI_RVALID, S1_AXI_RVALID, M_AXI_RVALID;
   logic        S0_AXI_RREADY, S1_AXI_RREADY, M_AXI_RREADY;
   logic        busy, grant_id;

   axi4_lite_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .S0_AXI_ARADDR(S0_AXI_ARADDR), .S0_AXI_ARVALID(S0_AXI_ARVALID), .S0_AXI_ARREADY(S0_AXI_ARREADY),
      .S0_AXI_RDATA(S0_AXI_RDATA), .S0_AXI_RRESP(S0_AXI_RRESP), .S0_AXI_RVALID(S0_AXI_RVALID),
      .S0_AXI_RREADY(S0_AXI_RREADY),
      .S1_AXI_ARADDR(S1_AXI_ARADDR), .S1_AXI_ARVALID(S1_AXI_ARVALID), .S1_AXI_ARREADY(S1_AXI_ARREADY),
      .S1_AXI_RDATA(S1_AXI_RDATA), .S1_AXI_RRESP(S1_AXI_RRESP), .S1_AXI_RVALID(S1_AXI_RVALID),
      .S1_AXI_RREADY(S1_AXI_RREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RREADY(M_AXI_RREADY),
      .busy(busy), .grant_id(grant_id)
   );

   typedef struct packed {
      logic        id;
      logic [31:0] addr;
      logic [7:0]  acyc;
   } ar_exp_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic [7:0]  vcyc;
   } r_exp_t;

   int          total = 0;
   int          bad   = 0;
   ar_exp_t     ar_exp[$];
   r_exp_t      r_exp0[$];
   r_exp_t      r_exp1[$];
   logic [31:0] req0_q[$];
   logic [31:0] req1_q[$];
   logic [33:0] mem [logic [31:0]];
   int          ar_stall = 0;
   int          r_lat    = 0;
   int          rr_stall0 = 0;
   int          rr_stall1 = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [33:0] lookup(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 34'd0;
   endfunction

   task automatic push_ar(input logic id, input logic [31:0] a);
      ar_exp.push_back('{id: id, addr: a, acyc: 8'(ar_stall + 1)});
   endtask

   task automatic issue(input logic id, input logic [31:0] a);
      logic [33:0] v;
      v = lookup(a);
      if (id) begin
         req1_q.push_back(a);
         r_exp1.push_back('{data: v[31:0], resp: v[33:32], vcyc: 8'(rr_stall1 + 1)});
      end else begin
         req0_q.push_back(a);
         r_exp0.push_back('{data: v[31:0], resp: v[33:32], vcyc: 8'(rr_stall0 + 1)});
      end
   endtask

   task automatic wait_idle();
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      while (!done && n < 600) begin
         @(negedge clk); #2;
         n++;
         done = (ar_exp.size() == 0) && (r_exp0.size() == 0) && (r_exp1.size() == 0) &&
                (req0_q.size() == 0) && (req1_q.size() == 0) && !busy &&
                !S0_AXI_ARVALID && !S1_AXI_ARVALID;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL wait_idle: timeout, busy=%0b ar_left=%0d r0_left=%0d r1_left=%0d",
                  busy, ar_exp.size(), r_exp0.size(), r_exp1.size());
      end
   endtask

   // Requester 0 address channel: raise the next queued address once the previous one is taken
   bit s0_hs = 1'b0;
   initial begin
      S0_AXI_ARVALID = 1'b0;
      S0_AXI_ARADDR  = '0;
      forever begin
         @(negedge clk);
         if (s0_hs) begin S0_AXI_ARVALID = 1'b0; S0_AXI_ARADDR = '0; s0_hs = 1'b0; end
         if (!S0_AXI_ARVALID && req0_q.size() > 0) begin
            S0_AXI_ARVALID = 1'b1;
            S0_AXI_ARADDR  = req0_q.pop_front();
         end
         #2;
         if (rst) begin S0_AXI_ARVALID = 1'b0; S0_AXI_ARADDR = '0; s0_hs = 1'b0; end
         else s0_hs = S0_AXI_ARVALID && S0_AXI_ARREADY;
      end
   end

   // Requester 1 address channel
   bit s1_hs = 1'b0;
   initial begin
      S1_AXI_ARVALID = 1'b0;
      S1_AXI_ARADDR  = '0;
      forever begin
         @(negedge clk);
         if (s1_hs) begin S1_AXI_ARVALID = 1'b0; S1_AXI_ARADDR = '0; s1_hs = 1'b0; end
         if (!S1_AXI_ARVALID && req1_q.size() > 0) begin
            S1_AXI_ARVALID = 1'b1;
            S1_AXI_ARADDR  = req1_q.pop_front();
         end
         #2;
         if (rst) begin S1_AXI_ARVALID = 1'b0; S1_AXI_ARADDR = '0; s1_hs = 1'b0; end
         else s1_hs = S1_AXI_ARVALID && S1_AXI_ARREADY;
      end
   end

   // Requester data channels: hold RREADY low for rr_stall cycles of RVALID
   initial begin
      int c0, c1;
      c0 = 0; c1 = 0;
      S0_AXI_RREADY = 1'b0;
      S1_AXI_RREADY = 1'b0;
      forever begin
         @(negedge clk); #1;
         if (rst || !S0_AXI_RVALID) begin S0_AXI_RREADY = 1'b0; c0 = 0; end
         else begin S0_AXI_RREADY = (c0 >= rr_stall0); c0++; end
         if (rst || !S1_AXI_RVALID) begin S1_AXI_RREADY = 1'b0; c1 = 0; end
         else begin S1_AXI_RREADY = (c1 >= rr_stall1); c1++; end
      end
   end

   // Downstream slave: ARREADY after ar_stall cycles, RVALID r_lat cycles after the AR handshake
   initial begin
      int          st, cnt;
      bit          ar_hs, r_hs;
      logic [31:0] a;
      logic [33:0] v;
      st = 0; cnt = 0; ar_hs = 1'b0; r_hs = 1'b0; a = '0;
      M_AXI_ARREADY = 1'b0;
      M_AXI_RVALID  = 1'b0;
      M_AXI_RDATA   = '0;
      M_AXI_RRESP   = 2'b00;
      forever begin
         @(negedge clk);
         if (ar_hs) begin M_AXI_ARREADY = 1'b0; st = 2; cnt = 0; ar_hs = 1'b0; end
         if (r_hs) begin
            M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00; st = 0; r_hs = 1'b0;
         end
         if (st == 0 && M_AXI_ARVALID) begin st = 1; cnt = 0; end
         if (st == 1) begin
            if (cnt >= ar_stall) M_AXI_ARREADY = 1'b1;
            else cnt++;
         end
         if (st == 2) begin
            if (cnt >= r_lat) begin
               v = lookup(a);
               M_AXI_RVALID = 1'b1;
               M_AXI_RDATA  = v[31:0];
               M_AXI_RRESP  = v[33:32];
               st = 3;
            end else cnt++;
         end
         #2;
         if (rst) begin
            st = 0; ar_hs = 1'b0; r_hs = 1'b0;
            M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
         end else begin
            ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
            if (ar_hs) a = M_AXI_ARADDR;
            r_hs = M_AXI_RVALID && M_AXI_RREADY;
         end
      end
   end

   // Monitor: pops expected AR and R beats whenever the DUT completes a handshake
   initial begin
      int          arcnt, rv0, rv1;
      logic [31:0] ar_prev;
      ar_exp_t     ea;
      r_exp_t      er;
      arcnt = 0; rv0 = 0; rv1 = 0; ar_prev = '0;
      forever begin
         @(negedge clk); #2;
         if (rst) begin
            arcnt = 0; rv0 = 0; rv1 = 0;
         end else begin
            if (M_AXI_ARVALID) begin
               arcnt++;
               if (arcnt > 1) chk("ar_addr_stable", 64'(M_AXI_ARADDR), 64'(ar_prev));
               ar_prev = M_AXI_ARADDR;
               if (M_AXI_ARREADY) begin
                  if (ar_exp.size() == 0) chk("ar_unexpected", 64'(M_AXI_ARADDR), 64'hFFFF_FFFF_FFFF_FFFF);
                  else begin
                     ea = ar_exp.pop_front();
                     chk("ar_addr", 64'(M_AXI_ARADDR), 64'(ea.addr));
                     chk("ar_grant_id", 64'(grant_id), 64'(ea.id));
                     chk("ar_cycles", 64'(arcnt), 64'(ea.acyc));
                  end
                  arcnt = 0;
               end
            end
            if (S0_AXI_RVALID && S1_AXI_RVALID) chk("both_rvalid", 64'd1, 64'd0);
            if (S0_AXI_RVALID) begin
               rv0++;
               chk("s0_rready_pass", 64'(M_AXI_RREADY), 64'(S0_AXI_RREADY));
               if (S0_AXI_RREADY) begin
                  if (r_exp0.size() == 0) chk("s0_r_unexpected", 64'(S0_AXI_RDATA), 64'hFFFF_FFFF_FFFF_FFFF);
                  else begin
                     er = r_exp0.pop_front();
                     chk("s0_rdata", 64'(S0_AXI_RDATA), 64'(er.data));
                     chk("s0_rresp", 64'(S0_AXI_RRESP), 64'(er.resp));
                     chk("s0_rvalid_cycles", 64'(rv0), 64'(er.vcyc));
                  end
                  rv0 = 0;
               end
            end
            if (S1_AXI_RVALID) begin
               rv1++;
               chk("s1_rready_pass", 64'(M_AXI_RREADY), 64'(S1_AXI_RREADY));
               if (S1_AXI_RREADY) begin
                  if (r_exp1.size() == 0) chk("s1_r_unexpected", 64'(S1_AXI_RDATA), 64'hFFFF_FFFF_FFFF_FFFF);
                  else begin
                     er = r_exp1.pop_front();
                     chk("s1_rdata", 64'(S1_AXI_RDATA), 64'(er.data));
                     chk("s1_rresp", 64'(S1_AXI_RRESP), 64'(er.resp));
                     chk("s1_rvalid_cycles", 64'(rv1), 64'(er.vcyc));
                  end
                  rv1 = 0;
               end
            end
            if (!busy) chk("idle_outputs",
                           64'({M_AXI_ARVALID, M_AXI_RREADY, S0_AXI_RVALID, S1_AXI_RVALID, M_AXI_ARADDR}), 64'd0);
         end
      end
   end

   // Directed sequence
   initial begin
      rst = 1'b1;
      mem[32'h0000_0100] = {RESP_OKAY,   32'hDEAD_BEEF};
      mem[32'h0000_0010] = {RESP_OKAY,   32'h1111_0010};
      mem[32'h0000_0020] = {RESP_OKAY,   32'h2222_0020};
      mem[32'h0000_0400] = {RESP_OKAY,   32'hCAFE_F00D};
      mem[32'h0000_0500] = {RESP_SLVERR, 32'h0000_0000};
      mem[32'h0000_0504] = {RESP_OKAY,   32'h5555_0504};
      mem[32'h0000_0600] = {RESP_OKAY,   32'h6666_0600};
      mem[32'h0000_0604] = {RESP_EXOKAY, 32'hABCD_0604};
      for (int k = 0; k < 4; k++) begin
         mem[32'h300 + 32'(k * 4)] = {RESP_OKAY, 32'h3000_0300 + 32'(k * 4)};
         mem[32'h380 + 32'(k * 4)] = {RESP_DECERR, 32'h3800_0380 + 32'(k * 4)};
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #2;
      chk("rst_busy",      64'(busy), 64'd0);
      chk("rst_grant_id",  64'(grant_id), 64'd0);
      chk("rst_m_arvalid", 64'(M_AXI_ARVALID), 64'd0);
      chk("rst_m_araddr",  64'(M_AXI_ARADDR), 64'd0);
      chk("rst_m_rready",  64'(M_AXI_RREADY), 64'd0);
      chk("rst_rvalids",   64'({S0_AXI_RVALID, S1_AXI_RVALID}), 64'd0);
      chk("rst_arreadys",  64'({S1_AXI_ARREADY, S0_AXI_ARREADY}), 64'b01);

      // single S0 read, one-cycle slave latency
      r_lat = 1;
      push_ar(1'b0, 32'h100);
      issue(1'b0, 32'h100);
      wait_idle();
      r_lat = 0;

      // simultaneous requests: S1 wins the tie either way here
      push_ar(1'b1, 32'h20);
      push_ar(1'b0, 32'h10);
      issue(1'b0, 32'h10);
      issue(1'b1, 32'h20);
      wait_idle();

      // both continuously requesting after a reset (last_grant back to 0)
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 4; k++) begin
         push_ar(1'b1, 32'h300 + 32'(k * 4));
         push_ar(1'b0, 32'h380 + 32'(k * 4));
      end
`else
      for (int k = 0; k < 4; k++) push_ar(1'b1, 32'h300 + 32'(k * 4));
      for (int k = 0; k < 4; k++) push_ar(1'b0, 32'h380 + 32'(k * 4));
`endif
      for (int k = 0; k < 4; k++) begin
         issue(1'b1, 32'h300 + 32'(k * 4));
         issue(1'b0, 32'h380 + 32'(k * 4));
      end
      wait_idle();

      // backpressure on both sides
      ar_stall  = 3;
      rr_stall1 = 2;
      push_ar(1'b1, 32'h400);
      issue(1'b1, 32'h400);
      wait_idle();
      ar_stall  = 0;
      rr_stall1 = 0;

      // error response passes through, next read is normal
      push_ar(1'b0, 32'h500);
      issue(1'b0, 32'h500);
      wait_idle();
      push_ar(1'b1, 32'h504);
      issue(1'b1, 32'h504);
      wait_idle();

      // reset while a beat is waiting in ST_DATA
      rr_stall0 = 50;
      push_ar(1'b0, 32'h600);
      issue(1'b0, 32'h600);
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk); #2;
            n++;
         end while (!S0_AXI_RVALID && n < 50);
         chk("t6_reach_data", 64'(S0_AXI_RVALID), 64'd1);
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      #2;
      chk("t6_busy",    64'(busy), 64'd0);
      chk("t6_m_rready", 64'(M_AXI_RREADY), 64'd0);
      chk("t6_rvalids", 64'({S0_AXI_RVALID, S1_AXI_RVALID}), 64'd0);
      r_exp0.delete();
      rr_stall0 = 0;
      push_ar(1'b0, 32'h604);
      issue(1'b0, 32'h604);
      wait_idle();

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
